// File: rtl/tdc_meas_sequencer.sv
// tdc_meas_sequencer: drives one averaged TDC measurement on the delay-unit chain.
// For each sample it presets the phase-reverse flops (pstb low), launches an edge
// (arm), strobes clk_phase_reverse, lets the chain settle, then counts the ones
// on the thermometer bus. After 2^NAVG_LOG2 samples it presents the mean code
// over a valid/ready handshake.
// Build option: define TDC_BUBBLE_CORR_EN to run a 3-tap majority bubble
// corrector over therm before the popcount. Latency is the same in both builds.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for start; outputs quiescent, last code held
// S_PRESET  | pstb low for PSTB_CYC cycles, arm low
// S_WINDOW  | pstb high, arm high for WIN_CYC cycles
// S_REVERSE | single-cycle clk_phase_reverse strobe, arm high
// S_SETTLE  | SETTLE_CYC cycles for the xnor outputs to settle, arm high
// S_SAMPLE  | accumulate popcount(therm); loop to S_PRESET or go to S_DONE
// S_DONE    | code_valid high, code/overflow held until code_ready

module tdc_meas_sequencer #(
  parameter int N_CELLS    = 64,
  parameter int CW         = $clog2(N_CELLS + 1),
  parameter int PSTB_CYC   = 2,
  parameter int WIN_CYC    = 4,
  parameter int SETTLE_CYC = 2,
  parameter int NAVG_LOG2  = 2
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               start,
  output logic               busy,
  output logic               pstb,
  output logic               arm,
  output logic               clk_phase_reverse,
  input  logic [N_CELLS-1:0] therm,
  output logic [CW-1:0]      code,
  output logic               code_valid,
  input  logic               code_ready,
  output logic               overflow
);

  localparam int AW   = CW + NAVG_LOG2;
  localparam int SW   = (NAVG_LOG2 > 0) ? NAVG_LOG2 : 1;
  localparam int NSMP = 1 << NAVG_LOG2;
  localparam int TW   = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESET,
    S_WINDOW,
    S_REVERSE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [TW-1:0]       r_tmr;
  logic [TW-1:0]       w_tmr_nxt;
  logic [SW-1:0]       r_smp;
  logic [AW-1:0]       r_acc;
  logic [AW-1:0]       w_acc_next;
  logic [N_CELLS-1:0]  w_therm_c;
  logic [CW-1:0]       w_ones;
  logic                w_accept;
  logic                w_last_smp;

  function automatic logic [CW-1:0] f_popcount(input logic [N_CELLS-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N_CELLS; i++) c = c + CW'(v[i]);
    return c;
  endfunction

`ifdef TDC_BUBBLE_CORR_EN
  logic [N_CELLS+1:0] w_ext;
  assign w_ext = {1'b0, therm, 1'b1};

  // Majority of each bit and its neighbours; the chain input side reads as 1, the far end as 0.
  always_comb begin
    w_therm_c = '0;
    for (int i = 0; i < N_CELLS; i++) begin
      w_therm_c[i] = (w_ext[i] & w_ext[i+1]) | (w_ext[i] & w_ext[i+2]) |
                     (w_ext[i+1] & w_ext[i+2]);
    end
  end
`else
  assign w_therm_c = therm;
`endif

  assign w_ones     = f_popcount(w_therm_c);
  assign w_acc_next = r_acc + AW'(w_ones);
  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_last_smp = (r_smp == SW'(NSMP - 1));

  // State and phase timer register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state <= S_IDLE;
      r_tmr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tmr   <= w_tmr_nxt;
    end
  end

  // Next state; the timer is loaded with (length-1) on entry and counts down to 0.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = (r_tmr != '0) ? r_tmr - TW'(1) : r_tmr;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_PRESET;
          w_tmr_nxt   = TW'(PSTB_CYC - 1);
        end
      end
      S_PRESET: begin
        if (r_tmr == '0) begin
          w_state_nxt = S_WINDOW;
          w_tmr_nxt   = TW'(WIN_CYC - 1);
        end
      end
      S_WINDOW: begin
        if (r_tmr == '0) w_state_nxt = S_REVERSE;
      end
      S_REVERSE: begin
        w_state_nxt = S_SETTLE;
        w_tmr_nxt   = TW'(SETTLE_CYC - 1);
      end
      S_SETTLE: begin
        if (r_tmr == '0) w_state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (w_last_smp) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_PRESET;
          w_tmr_nxt   = TW'(PSTB_CYC - 1);
        end
      end
      S_DONE: begin
        if (code_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs (decoded from the next state) and the sample datapath.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      pstb              <= 1'b0;
      arm               <= 1'b0;
      clk_phase_reverse <= 1'b0;
      busy              <= 1'b0;
      code_valid        <= 1'b0;
      code              <= '0;
      overflow          <= 1'b0;
      r_acc             <= '0;
      r_smp             <= '0;
    end else begin
      pstb              <= (w_state_nxt != S_PRESET);
      arm               <= (w_state_nxt == S_WINDOW) || (w_state_nxt == S_REVERSE) ||
                           (w_state_nxt == S_SETTLE) || (w_state_nxt == S_SAMPLE);
      clk_phase_reverse <= (w_state_nxt == S_REVERSE);
      busy              <= (w_state_nxt != S_IDLE);
      code_valid        <= (w_state_nxt == S_DONE);
      if (w_accept) begin
        r_acc    <= '0;
        r_smp    <= '0;
        overflow <= 1'b0;
      end else if (r_state == S_SAMPLE) begin
        r_acc <= w_acc_next;
        if (&w_therm_c) overflow <= 1'b1;
        if (w_last_smp) begin
          code <= CW'(w_acc_next >> NAVG_LOG2);
        end else begin
          r_smp <= r_smp + SW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_tdc_meas_sequencer.sv
// Directed bench for tdc_meas_sequencer with default parameters (64 cells,
// 10-cycle samples, 4 samples per result, 41-cycle latency).
module tb_tdc_meas_sequencer;

  logic        clk;
  logic        rstb;
  logic        start;
  logic        busy;
  logic        pstb;
  logic        arm;
  logic        clk_phase_reverse;
  logic [63:0] therm;
  logic [6:0]  code;
  logic        code_valid;
  logic        code_ready;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  tdc_meas_sequencer dut (
    .clk               (clk),
    .rstb              (rstb),
    .start             (start),
    .busy              (busy),
    .pstb              (pstb),
    .arm               (arm),
    .clk_phase_reverse (clk_phase_reverse),
    .therm             (therm),
    .code              (code),
    .code_valid        (code_valid),
    .code_ready        (code_ready),
    .overflow          (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pulses start, feeds t0..t3 to the four SAMPLE cycles and stops at the
  // first cycle with code_valid high (left #1 after that edge). lat = -1 on timeout.
  task automatic run_meas(input logic [63:0] t0, input logic [63:0] t1,
                          input logic [63:0] t2, input logic [63:0] t3,
                          input logic rdy, output int lat, output int pstb_lo,
                          output int cpr_cnt, output int busy_lo);
    logic [63:0] tv [4];
    int idx;
    tv[0] = t0; tv[1] = t1; tv[2] = t2; tv[3] = t3;
    lat = -1; pstb_lo = 0; cpr_cnt = 0; busy_lo = 0;
    @(negedge clk);
    start = 1'b1; therm = t0; code_ready = rdy;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      idx = (cyc - 1) / 10;
      if (idx > 3) idx = 3;
      therm = tv[idx];
      if (code_valid) begin
        lat = cyc;
        break;
      end
      if (!pstb) pstb_lo++;
      if (clk_phase_reverse) cpr_cnt++;
      if (!busy) busy_lo++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rstb = 1'b0; start = 1'b0; therm = '0; code_ready = 1'b0;
    #12;
    n_tests++;
    if ({pstb, arm, clk_phase_reverse, busy, code_valid, overflow} !== 6'b0 || code !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_vals: pstb=%b arm=%b cpr=%b busy=%b valid=%b ovf=%b code=%0d, want all 0",
               pstb, arm, clk_phase_reverse, busy, code_valid, overflow, code);
    end
    @(negedge clk) rstb = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (pstb !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: pstb=%b busy=%b, want pstb=1 busy=0", pstb, busy);
    end
  endtask

  task automatic test_basic;
    int lat, plo, cpr, blo;
    run_meas(64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b1, lat, plo, cpr, blo);
    n_tests++;
    if (lat !== 41) begin n_fail++; $display("FAIL basic_latency: got %0d, want 41", lat); end
    n_tests++;
    if (code !== 7'd32 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL basic_code: code=%0d ovf=%b, want 32 ovf=0", code, overflow);
    end
    n_tests++;
    if (busy !== 1'b1 || blo !== 0) begin
      n_fail++; $display("FAIL basic_busy: busy=%b low_cycles=%0d, want 1 and 0", busy, blo);
    end
    n_tests++;
    if (plo !== 8 || cpr !== 4) begin
      n_fail++; $display("FAIL basic_strobes: pstb_lo=%0d cpr=%0d, want 8 and 4", plo, cpr);
    end
    @(posedge clk); #1;
    n_tests++;
    if (busy !== 1'b0 || code_valid !== 1'b0 || code !== 7'd32) begin
      n_fail++;
      $display("FAIL basic_idle: busy=%b valid=%b code=%0d, want 0 0 32", busy, code_valid, code);
    end
  endtask

  task automatic test_average;
    int lat, plo, cpr, blo;
    run_meas(64'h3FF, 64'h7FF, 64'hFFF, 64'h1FFF, 1'b1, lat, plo, cpr, blo);
    n_tests++;
    if (lat !== 41 || code !== 7'd11 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL average: lat=%0d code=%0d ovf=%b, want 41 11 0", lat, code, overflow);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow;
    int lat, plo, cpr, blo;
    run_meas(64'hFFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFFF, 64'hFFFFF, 1'b1, lat, plo, cpr, blo);
    n_tests++;
    if (lat !== 41 || code !== 7'd31 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow: lat=%0d code=%0d ovf=%b, want 41 31 1", lat, code, overflow);
    end
    @(posedge clk); #1;
    n_tests++;
    if (overflow !== 1'b1 || code !== 7'd31 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_hold: ovf=%b code=%0d busy=%b, want 1 31 0", overflow, code, busy);
    end
  endtask

  task automatic test_backpressure;
    int lat, plo, cpr, blo;
    int bad, busy_after;
    run_meas(64'hFF, 64'hFF, 64'hFF, 64'hFF, 1'b0, lat, plo, cpr, blo);
    n_tests++;
    if (lat !== 41 || code !== 7'd8 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_first: lat=%0d code=%0d ovf=%b, want 41 8 0", lat, code, overflow);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      start = (i == 1);
      if (code_valid !== 1'b1 || code !== 7'd8 || overflow !== 1'b0 || busy !== 1'b1) bad++;
    end
    start = 1'b0;
    n_tests++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL bp_hold: %0d unstable cycles, want 0", bad);
    end
    code_ready = 1'b1;
    @(posedge clk); #1;
    code_ready = 1'b0;
    n_tests++;
    if (code_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: valid=%b busy=%b, want 0 0", code_valid, busy);
    end
    busy_after = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (busy || code_valid) busy_after++;
    end
    n_tests++;
    if (busy_after !== 0) begin
      n_fail++; $display("FAIL bp_no_queue: %0d busy cycles, want 0", busy_after);
    end
  endtask

  task automatic test_abort;
    int lat, plo, cpr, blo;
    @(negedge clk);
    start = 1'b1; therm = 64'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    n_tests++;
    if (arm !== 1'b1 || pstb !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL abort_window: arm=%b pstb=%b busy=%b, want 1 1 1", arm, pstb, busy);
    end
    #2 rstb = 1'b0;
    #1;
    n_tests++;
    if ({pstb, arm, clk_phase_reverse, busy, code_valid, overflow} !== 6'b0 || code !== 7'd0) begin
      n_fail++;
      $display("FAIL abort_reset: pstb=%b arm=%b cpr=%b busy=%b valid=%b ovf=%b code=%0d, want all 0",
               pstb, arm, clk_phase_reverse, busy, code_valid, overflow, code);
    end
    @(negedge clk) rstb = 1'b1;
    @(posedge clk); #1;
    run_meas(64'hFF_FFFF_FFFF, 64'hFF_FFFF_FFFF, 64'hFF_FFFF_FFFF, 64'hFF_FFFF_FFFF, 1'b1,
             lat, plo, cpr, blo);
    n_tests++;
    if (lat !== 41 || code !== 7'd40) begin
      n_fail++; $display("FAIL abort_rerun: lat=%0d code=%0d, want 41 40", lat, code);
    end
    n_tests++;
    if (plo !== 8 || cpr !== 4 || blo !== 0) begin
      n_fail++;
      $display("FAIL abort_strobes: pstb_lo=%0d cpr=%0d busy_lo=%0d, want 8 4 0", plo, cpr, blo);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_bubble;
    int lat, plo, cpr, blo;
    logic [6:0] exp_code;
`ifdef TDC_BUBBLE_CORR_EN
    exp_code = 7'd20;
`else
    exp_code = 7'd19;
`endif
    run_meas(64'hFFBFF, 64'hFFBFF, 64'hFFBFF, 64'hFFBFF, 1'b1, lat, plo, cpr, blo);
    n_tests++;
    if (lat !== 41 || code !== exp_code) begin
      n_fail++; $display("FAIL bubble: lat=%0d code=%0d, want 41 %0d", lat, code, exp_code);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_average();
    test_overflow();
    test_backpressure();
    test_abort();
    test_bubble();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tdc_meas_sequencer.md
Name: tdc_meas_sequencer

Overview:
Sequences one TDC measurement on the delay-unit chain and averages repeated samples into one code. Per sample it presets the phase-reverse flops (pstb), launches an edge into the chain (arm), strobes clk_phase_reverse, then samples the N-bit xnor thermometer bus. Sits between the digital control/JTAG domain and the analog TDC chain. Returns an averaged code over a valid/ready handshake.

Parameters:
N_CELLS, 64, number of delay units; width of the thermometer bus
CW, $clog2(N_CELLS+1) (=7), width of the output code
PSTB_CYC, 2, cycles pstb is held low per sample (min 1)
WIN_CYC, 4, cycles arm is held high per sample (min 1)
SETTLE_CYC, 2, cycles waited after the clk_phase_reverse pulse before sampling (min 1)
NAVG_LOG2, 2, log2 of the samples averaged per result (0..4)

Ports:
clk  input  1  system clock; all state on posedge
rstb  input  1  asynchronous active-low reset
start  input  1  measurement request; accepted only in IDLE
busy  output  1  high from acceptance until the handshake completes
pstb  output  CW-independent 1  active-low preset to the phase_reverse flops of every delay unit
arm  output  1  edge launched into inv_in of the first delay unit
clk_phase_reverse  output  1  one-cycle strobe to the delay units
therm  input  N_CELLS  xnor_out bus; bit 0 is nearest the chain input
code  output  CW  averaged thermometer count
code_valid  output  1  code is valid
code_ready  input  1  consumer accepts code
overflow  output  1  at least one sample in this result was all ones

Behaviour:
- Reset (async, rstb=0): state=IDLE; pstb=0, arm=0, clk_phase_reverse=0, busy=0, code=0, code_valid=0, overflow=0; sample counter and accumulator cleared. pstb goes to 1 on the first clock after rstb deasserts.
- All outputs are registered. No combinational path from inputs to outputs.
- States: IDLE -> PRESET -> WINDOW -> REVERSE -> SETTLE -> SAMPLE -> (PRESET | DONE) -> IDLE.
- IDLE: if start=1 at an edge, then on the next cycle: PRESET, busy=1, acc=0, sample count=0, overflow=0.
- PRESET: pstb=0 for PSTB_CYC cycles; arm=0.
- WINDOW: pstb=1, arm=1 for WIN_CYC cycles.
- REVERSE: clk_phase_reverse=1 for exactly 1 cycle; arm stays 1.
- SETTLE: SETTLE_CYC cycles; arm stays 1.
- SAMPLE: 1 cycle. Register therm and compute ones = popcount(therm), which is CW wide.
  - acc += ones. acc is CW+NAVG_LOG2 bits and cannot overflow.
  - If therm is all ones, set overflow=1 (sticky for this result).
  - arm returns to 0 on leaving SAMPLE.
  - If sample count < 2^NAVG_LOG2-1: increment the count and go to PRESET. Otherwise go to DONE.
- DONE: code = acc >> NAVG_LOG2 (truncating), code_valid=1.
  - code, code_valid and overflow are held stable until code_valid and code_ready are both 1 at an edge.
  - The next cycle: IDLE, code_valid=0, busy=0. code and overflow hold their last values.
- Per-sample length = PSTB_CYC+WIN_CYC+1+SETTLE_CYC+1 (=10 with defaults).
- Latency: start accepted at edge 0 -> code_valid high at cycle 1 + 2^NAVG_LOG2 * 10 (=41 with defaults).
- start while busy=1 is ignored, including during DONE. It is not queued.
- code_ready while code_valid=0 is ignored.
- rstb asserted mid-operation aborts immediately to the reset values. Any partial result is discarded.
- therm is treated as already synchronous; the block does not synchronise it.

Optional Feature:
Macro TDC_BUBBLE_CORR_EN.
- Defined: before popcount, each bit i is replaced by majority(therm[i-1], therm[i], therm[i+1]), with therm[-1]=1 and therm[N_CELLS]=0. The overflow test uses the corrected vector.
- Undefined: raw popcount of therm. No extra logic.
- Latency is identical in both builds.

Test Plan:
1. therm held at 32 ones (bits 0..31), start pulse at cycle 0 -> code_valid at cycle 41, code=32, overflow=0, busy high cycles 1..41 with code_ready=1.
2. therm = 10, 11, 12, 13 ones over the four SAMPLE cycles -> acc=46, code=11.
3. therm all ones on one sample and 20 ones on the other three -> code=(64+60)>>2=31, overflow=1.
4. code_ready held 0 for 5 cycles after code_valid, start pulsed during the wait -> code, code_valid and overflow stable; start ignored; IDLE one cycle after the ready handshake; one result only.
5. rstb pulsed low during WINDOW -> all outputs take their reset values immediately. A new start then runs the full 41-cycle sequence; per sample, pstb is low for 2 cycles and clk_phase_reverse pulses exactly once.
6. therm = bits 0..19 set except bit 10 -> code=19 without TDC_BUBBLE_CORR_EN, code=20 with it.
